// File: rtl/disp_mux.sv
// Eight-digit seven-segment display driver: an 8-entry frame buffer written by the
// calculator core, scanned one common-anode digit at a time, with an "Error" banner latch.
module disp_mux #(
  parameter int REFRESH_DIV = 50000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] status,
  input  logic [3:0] data,
  input  logic [3:0] pos,
  output logic [7:0] an,
  output logic [7:0] seg
);

  localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

  localparam logic [1:0] ST_ERROR = 2'b00;
  localparam logic [1:0] ST_BUSY  = 2'b01;
  localparam logic [1:0] ST_READY = 2'b10;
  localparam logic [1:0] ST_PRINT = 2'b11;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_E     = 8'h86;
  localparam logic [7:0] SEG_R     = 8'hAF;
  localparam logic [7:0] SEG_O     = 8'hA3;

  logic [CNT_W-1:0] r_div_cnt;
  logic [2:0]       r_idx;
  logic [1:0]       r_prev_status;
  logic             r_err;
  logic [7:0]       r_an;
  logic [7:0]       r_seg;

  logic             w_write;
  logic             w_clear;
  logic             w_tick;
  logic [31:0]      w_digits;
  logic [7:0]       w_blank;
  logic [3:0]       w_cur_digit;
  logic             w_cur_blank;
  logic [7:0]       w_seg_next;

  assign w_write = (status == ST_PRINT) && !pos[3];
  assign w_clear = (status == ST_BUSY) && (r_prev_status != ST_BUSY);
  assign w_tick  = (r_div_cnt == CNT_LAST);

  // Active-low digit patterns, dp bit kept off.
  function automatic logic [7:0] decode_digit(input logic [3:0] d);
    logic [7:0] s;
    s = SEG_BLANK;
    case (d)
      4'd0: s = 8'hC0;
      4'd1: s = 8'hF9;
      4'd2: s = 8'hA4;
      4'd3: s = 8'hB0;
      4'd4: s = 8'h99;
      4'd5: s = 8'h92;
      4'd6: s = 8'h82;
      4'd7: s = 8'hF8;
      4'd8: s = 8'h80;
      4'd9: s = 8'h90;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // "Error" spelled across positions 4..0, upper three positions dark.
  function automatic logic [7:0] banner_glyph(input logic [2:0] p);
    logic [7:0] s;
    s = SEG_BLANK;
    case (p)
      3'd4: s = SEG_E;
      3'd3: s = SEG_R;
      3'd2: s = SEG_R;
      3'd1: s = SEG_O;
      3'd0: s = SEG_R;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_entry
      logic [3:0] r_digit;
      logic       r_blank;

      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          r_digit <= '0;
          r_blank <= 1'b1;
        end else if (w_clear) begin
          r_blank <= 1'b1;
        end else if (w_write && (pos[2:0] == 3'(gi))) begin
          r_digit <= data;
          r_blank <= (data > 4'd9);
        end
      end

      assign w_digits[gi*4 +: 4] = r_digit;
      assign w_blank[gi]         = r_blank;
    end
  endgenerate

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_div_cnt <= '0;
      r_idx     <= '0;
    end else if (w_tick) begin
      r_div_cnt <= '0;
      r_idx     <= r_idx + 3'd1;
    end else begin
      r_div_cnt <= r_div_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_prev_status <= ST_READY;
      r_err         <= 1'b0;
    end else begin
      r_prev_status <= status;
      if (status == ST_ERROR) r_err <= 1'b1;
    end
  end

  assign w_cur_digit = w_digits[{r_idx, 2'b00} +: 4];
  assign w_cur_blank = w_blank[r_idx];

  always_comb begin
    w_seg_next = SEG_BLANK;
    if (r_err) begin
      w_seg_next = banner_glyph(r_idx);
    end else if (!w_cur_blank) begin
      w_seg_next = decode_digit(w_cur_digit);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_an  <= 8'hFF;
      r_seg <= SEG_BLANK;
    end else begin
      r_an  <= ~(8'd1 << r_idx);
      r_seg <= w_seg_next;
    end
  end

  assign an  = r_an;
  assign seg = r_seg;

endmodule

// File: doc/disp_mux.md
# disp_mux

Display driver downstream of the calculator core. Captures digits streamed on `data`/`pos` into an 8-entry frame buffer and time-multiplexes them onto eight common-anode seven-segment displays. Clears the frame when the core enters busy and latches an "Error" banner when the core reports error. Position 0 is the rightmost (least-significant) digit.

## Interface
- `REFRESH_DIV`, 50000: clock cycles each digit stays enabled; legal range ≥ 2.
- `clock`  in  1  system clock, all logic on rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `status`  in  2  core status: 00 error, 01 busy, 10 ready, 11 printing.
- `data`  in  4  digit value to write (0–9 valid).
- `pos`  in  4  target position for `data` (0–7 valid).
- `an`  out  8  anode enables, active-low one-hot; bit i = position i.
- `seg`  out  8  segments, active-low, order {dp,g,f,e,d,c,b,a}.

## Operation
- Frame buffer: 8 entries × 4 bits plus a blank flag per entry; reset sets all entries blank.
- Write: in any cycle with `status`==11 and `pos`<8, entry `pos[2:0]` takes `data` and its blank flag clears. If `data`>9, the entry is set blank instead. Writes with `pos`≥8 are ignored.
- Clear: `prev_status` register, reset value 10. A cycle with `status`==01 and `prev_status`!=01 sets all entries blank. Sustained 01 does not re-clear and does not write.
- Error latch: set in any cycle with `status`==00. Cleared only by `reset`. While set:
  - positions 4..0 show E,r,r,o,r (pos4=E, pos3=r, pos2=r, pos1=o, pos0=r);
  - positions 7..5 show blank;
  - the buffer is still written but not shown.
- `status`==10: no buffer change; the display shows the buffer contents.
- Scan:
  - `div_cnt` counts 0..REFRESH_DIV-1 and wraps.
  - When `div_cnt`==REFRESH_DIV-1, the 3-bit `idx` increments, wrapping 7→0.
  - Reset: `div_cnt`=0, `idx`=0.
- Decode (active-low, dp always 1):
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90
  - blank=FF, E=86, r=AF, o=A3
- Outputs registered: each cycle `an` ← ~(1<<`idx`) and `seg` ← decode(the glyph selected by the error latch or by entry `idx`).

## Timing
- Reset values: `an`=FF, `seg`=FF, error latch=0, `prev_status`=10.
- First clock after reset release: `an`=FE, `seg`=FF.
- Write-to-pin latency: the write lands at edge N. If `idx` equals that position, `seg` shows the new glyph from edge N+1.
- Clear latency: same as write, one cycle to the buffer plus one cycle to the pins.
- Error latch: set at edge N when `status`==00. The banner appears on `seg` at edge N+1 for whichever position is being scanned.
- Each `an` pattern holds exactly REFRESH_DIV cycles; a full frame is 8×REFRESH_DIV cycles.
- Scan runs continuously, independent of `status`, writes, clears and the error latch.
- Reset asserted mid-scan or mid-write: all state returns to reset values immediately (asynchronous). No partial write survives.
- Simultaneous events: clear and write never coincide, because each needs a different `status`. The error latch and a write may not coincide either. Latching error in the same cycle as a clear edge is not possible for the same reason.

## Test plan
- Reset, REFRESH_DIV=4, no writes → `an` steps FE,FD,FB,…,7F,FE every 4 cycles; `seg`=FF throughout.
- `status`=11, writes (pos0,data3), (pos1,data7), then `status`=10 → `seg`=B0 while `an`=FE, F8 while `an`=FD, FF for all other positions.
- Fill all 8 positions, then 10→01 transition → all `seg`=FF from the next frame; holding 01 for 20 cycles followed by writes shows only the new digits.
- `status`=11 with pos=9, data=5 and with pos=2, data=12 → buffer unchanged for pos 9; position 2 is blank (`seg`=FF).
- `status`=00 for one cycle, then 10 → positions 4..0 show 86,AF,AF,A3,AF and 7..5 show FF indefinitely. Subsequent writes are not visible; `reset` restores blank.
- Assert `reset` for one cycle mid-frame after writes → `an`=FF and `seg`=FF during reset; scan restarts at `an`=FE with all positions blank.
